// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises the raw lines, deframes 11-bit
// frames with start/odd-parity/stop checking, and buffers good bytes in a FIFO.
module ps2_rx_fifo #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ps2_clk,
    input  logic                     ps2_dat,
    input  logic                     stall,
    input  logic                     ovf_clr,
    output logic [7:0]               ps2_data,
    output logic                     ps2_recFlag,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     frame_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state, state_nxt;
    logic            clk_s1, clk_s2, clk_s3;
    logic            dat_s1, dat_s2;
    logic            fe;
    logic [7:0]      shreg;
    logic [2:0]      bit_cnt;
    logic            par;
    logic [TW-1:0]   tmo_cnt;
    logic            tmo_hit;
    logic            shift_en, par_en, push_req, bad_frame;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            full, empty, push, pop;

    // Idle-high lines: presetting the synchronisers to 1 avoids a false edge out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    assign fe      = clk_s3 & ~clk_s2;
    assign tmo_hit = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A falling edge always takes priority over an expiring timeout.
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        push_req  = 1'b0;
        bad_frame = 1'b0;
        if (fe) begin
            case (state)
                IDLE: begin
                    if (!dat_s2) state_nxt = DATA;
                end
                DATA: begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: begin
                    par_en    = 1'b1;
                    state_nxt = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (dat_s2 && (^{shreg, par})) push_req  = 1'b1;
                    else                           bad_frame = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (tmo_hit) begin
            state_nxt = IDLE;
            bad_frame = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg     <= 8'h00;
            bit_cnt   <= 3'd0;
            par       <= 1'b0;
            tmo_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            if (fe && state == IDLE) begin
                bit_cnt <= 3'd0;
            end else if (shift_en) begin
                shreg   <= {dat_s2, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (par_en) par <= dat_s2;
            if (state == IDLE || fe) tmo_cnt <= '0;
            else                     tmo_cnt <= tmo_cnt + 1'b1;
            frame_err <= bad_frame;
        end
    end

    // Fullness comes from the registered count, so a same-cycle pop never frees a slot for the push.
    assign full  = (fifo_count == (AW + 1)'(DEPTH));
    assign empty = (fifo_count == '0);
    assign push  = push_req && !full;
    assign pop   = !empty && !stall && !ps2_recFlag;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            ps2_data    <= 8'h00;
            ps2_recFlag <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (pop) ps2_data <= mem[rd_ptr];
            ps2_recFlag <= pop;
            if (push_req && full) overflow <= 1'b1;
            else if (ovf_clr)     overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomised and directed bench for ps2_rx_fifo against a frame-level model
// (queue of expected bytes, error count and overflow flag).
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int TMO   = 300;
    localparam int HALF  = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       stall = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] ps2_data;
    logic       ps2_recFlag;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       frame_err;

    int checks = 0;
    int passed = 0;

    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] model_fifo[$];
    int         obs_err = 0;
    int         exp_err = 0;
    int         rec_consec = 0;
    logic       prev_rec = 1'b0;
    logic       model_ovf = 1'b0;

    always #5 clk = ~clk;

    ps2_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .stall(stall), .ovf_clr(ovf_clr), .ps2_data(ps2_data),
        .ps2_recFlag(ps2_recFlag), .fifo_count(fifo_count),
        .overflow(overflow), .frame_err(frame_err)
    );

    // Output monitor sampling 1 ns after each rising edge.
    always @(posedge clk) begin
        #1;
        if (ps2_recFlag) begin
            obs_q.push_back(ps2_data);
            if (prev_rec) rec_consec++;
        end
        if (frame_err) obs_err++;
        prev_rec = ps2_recFlag;
    end

    // Frame-level reference: a good frame has odd parity over data+parity and stop=1.
    task automatic model_frame(input logic [7:0] d, input logic p, input logic s);
        if (((^d) ^ p) && s) begin
            if (model_fifo.size() < DEPTH) model_fifo.push_back(d);
            else                           model_ovf = 1'b1;
        end else begin
            exp_err++;
        end
    endtask

    task automatic model_drain();
        while (model_fifo.size() > 0) exp_q.push_back(model_fifo.pop_front());
    endtask

    // One PS/2 bit; with meas set, lat returns the sample index after the fall at which recFlag rose.
    task automatic ps2_bit(input logic b, input bit meas, output int lat);
        lat = -1;
        ps2_dat = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        for (int k = 1; k <= HALF; k++) begin
            @(posedge clk);
            #1;
            if (meas && lat < 0 && ps2_recFlag) lat = k;
        end
        @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int nbits, input bit meas, output int lat);
        logic [10:0] f;
        int l;
        f = {s, p, d, 1'b0};
        lat = -1;
        for (int i = 0; i < nbits; i++) begin
            ps2_bit(f[i], meas && (i == 10), l);
            if (i == 10) lat = l;
        end
        ps2_dat = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] d);
        int l;
        send_frame(d, ~(^d), 1'b1, 11, 1'b0, l);
        model_frame(d, ~(^d), 1'b1);
        if (!stall) model_drain();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ps2_data !== 8'h00) $display("[TB] FAIL reset_data: got %h expected 00", ps2_data); else passed++;
        checks++; if (ps2_recFlag !== 1'b0) $display("[TB] FAIL reset_rec: got %b expected 0", ps2_recFlag); else passed++;
        checks++; if (fifo_count !== 4'd0) $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); else passed++;
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_ovf: got %b expected 0", overflow); else passed++;
        checks++; if (frame_err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", frame_err); else passed++;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        obs_q.delete();
    endtask

    task automatic test_single();
        int lat;
        // Two synchroniser flops plus the edge flop make fe one cycle after the second sample; recFlag follows 2 cycles later.
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1, lat);
        model_frame(8'h1C, 1'b0, 1'b1);
        model_drain();
        checks++; if (lat !== 4) $display("[TB] FAIL single_latency: got %0d expected 4", lat); else passed++;
        checks++; if (obs_q.size() !== 1) $display("[TB] FAIL single_pulses: got %0d expected 1", obs_q.size()); else passed++;
        checks++; if (obs_q.size() > 0 && obs_q[0] !== 8'h1C) $display("[TB] FAIL single_data: got %h expected 1C", obs_q[0]); else passed++;
        checks++; if (obs_err !== exp_err) $display("[TB] FAIL single_err: got %0d expected %0d", obs_err, exp_err); else passed++;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_sequence();
        send_good(8'h1C);
        send_good(8'hF0);
        send_good(8'h1C);
        checks++; if (obs_q.size() !== exp_q.size()) $display("[TB] FAIL seq_len: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
                $display("[TB] FAIL seq_data[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, exp_q[i]);
            else passed++;
        end
        checks++; if (fifo_count !== 4'd0) $display("[TB] FAIL seq_count: got %0d expected 0", fifo_count); else passed++;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_errors();
        int l;
        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, l);
        model_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0, l);
        model_frame(8'h1C, 1'b0, 1'b0);
        checks++; if (obs_err !== exp_err) $display("[TB] FAIL err_pulses: got %0d expected %0d", obs_err, exp_err); else passed++;
        checks++; if (obs_q.size() !== 0) $display("[TB] FAIL err_norec: got %0d expected 0", obs_q.size()); else passed++;
        checks++; if (fifo_count !== 4'd0) $display("[TB] FAIL err_count: got %0d expected 0", fifo_count); else passed++;
        obs_q.delete();
    endtask

    task automatic test_timeout();
        int l;
        send_frame(8'h0A, 1'b0, 1'b1, 5, 1'b0, l);
        repeat (TMO + 20) @(negedge clk);
        exp_err++;
        checks++; if (obs_err !== exp_err) $display("[TB] FAIL tmo_err: got %0d expected %0d", obs_err, exp_err); else passed++;
        send_good(8'h16);
        checks++; if (obs_q.size() !== 1 || obs_q[0] !== 8'h16)
            $display("[TB] FAIL tmo_data: got %0d bytes first %h expected 1 byte 16", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'hxx);
        else passed++;
        checks++; if (obs_err !== exp_err) $display("[TB] FAIL tmo_err_after: got %0d expected %0d", obs_err, exp_err); else passed++;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_overflow();
        stall = 1'b1;
        for (int i = 1; i <= DEPTH + 1; i++) send_good(8'(i));
        checks++; if (fifo_count !== 4'(model_fifo.size())) $display("[TB] FAIL ovf_count: got %0d expected %0d", fifo_count, model_fifo.size()); else passed++;
        checks++; if (overflow !== model_ovf) $display("[TB] FAIL ovf_flag: got %b expected %b", overflow, model_ovf); else passed++;
        checks++; if (obs_q.size() !== 0) $display("[TB] FAIL ovf_stalled: got %0d expected 0", obs_q.size()); else passed++;
        stall = 1'b0;
        repeat (40) @(negedge clk);
        model_drain();
        checks++; if (obs_q.size() !== exp_q.size()) $display("[TB] FAIL ovf_len: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
                $display("[TB] FAIL ovf_data[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, exp_q[i]);
            else passed++;
        end
        checks++; if (rec_consec !== 0) $display("[TB] FAIL back_to_back: got %0d expected 0", rec_consec); else passed++;
        checks++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); else passed++;
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        model_ovf = 1'b0;
        @(negedge clk);
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL ovf_clr: got %b expected 0", overflow); else passed++;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        int l;
        send_frame(8'hFF, 1'b0, 1'b1, 5, 1'b0, l);
        rst = 1'b0;
        model_fifo.delete();
        model_ovf = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ps2_data !== 8'h00 || ps2_recFlag !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b0 || frame_err !== 1'b0)
            $display("[TB] FAIL midreset_outputs: got %h/%b/%0d/%b/%b expected 00/0/0/0/0", ps2_data, ps2_recFlag, fifo_count, overflow, frame_err);
        else passed++;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        send_good(8'h45);
        checks++; if (obs_q.size() !== 1 || obs_q[0] !== 8'h45)
            $display("[TB] FAIL midreset_data: got %0d bytes first %h expected 1 byte 45", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'hxx);
        else passed++;
        checks++; if (obs_err !== exp_err) $display("[TB] FAIL midreset_err: got %0d expected %0d", obs_err, exp_err); else passed++;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       p, s;
        int         l;
        for (int n = 0; n < 14; n++) begin
            stall = ($urandom_range(0, 2) == 0);
            d = 8'($urandom);
            p = ~(^d);
            s = 1'b1;
            if ($urandom_range(0, 4) == 0) p = ~p;
            if ($urandom_range(0, 6) == 0) s = 1'b0;
            send_frame(d, p, s, 11, 1'b0, l);
            model_frame(d, p, s);
            if (!stall) model_drain();
        end
        checks++; if (fifo_count !== 4'(model_fifo.size())) $display("[TB] FAIL rand_count: got %0d expected %0d", fifo_count, model_fifo.size()); else passed++;
        checks++; if (overflow !== model_ovf) $display("[TB] FAIL rand_ovf: got %b expected %b", overflow, model_ovf); else passed++;
        stall = 1'b0;
        repeat (40) @(negedge clk);
        model_drain();
        checks++; if (obs_q.size() !== exp_q.size()) $display("[TB] FAIL rand_len: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
                $display("[TB] FAIL rand_data[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, exp_q[i]);
            else passed++;
        end
        checks++; if (obs_err !== exp_err) $display("[TB] FAIL rand_err: got %0d expected %0d", obs_err, exp_err); else passed++;
        checks++; if (rec_consec !== 0) $display("[TB] FAIL rand_back_to_back: got %0d expected 0", rec_consec); else passed++;
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_sequence();
        test_errors();
        test_timeout();
        test_overflow();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
